// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle controller: state enum, select encodings,
// opcode classes and the packed control word produced by the output decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_EXTIMM = 2'b01,
    SRCB_FOUR   = 2'b10
  } alusrcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_RDATA     = 2'b01,
    RES_ALURESULT = 2'b10
  } resultsrc_e;

  typedef enum logic [1:0] {
    OP_DATA    = 2'b00,
    OP_MEM     = 2'b01,
    OP_BRANCH  = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam int unsigned FUNCT_I = 5;
  localparam int unsigned FUNCT_L = 0;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    alusrcb_e   alusrcb;
    resultsrc_e resultsrc;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  // FETCH-style selects (PC + 4 on the address path) with every strobe off.
  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c           = '0;
    c.alusrca   = 1'b1;
    c.alusrcb   = SRCB_FOUR;
    c.resultsrc = RES_ALURESULT;
    return c;
  endfunction

endpackage

// File: rtl/mc_fsm_if.sv
// Control bus between the multi-cycle controller (master) and its datapath (slave).
interface mc_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, State
  );
endinterface

// File: rtl/mc_outdec.sv
// Moore output table: state -> control word. Only the FETCH strobes look at
// MemReady, and they are forced off while reset is held.
module mc_outdec
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   hold,
  output ctrl_t  cw
);

  always_comb begin
    cw = idle_ctrl();
    case (state)
      FETCH: begin
        cw.irwrite = mem_ready & ~hold;
        cw.nextpc  = mem_ready & ~hold;
      end
      DECODE: ;
      MEMADR: begin
        cw.alusrca = 1'b0;
        cw.alusrcb = SRCB_EXTIMM;
        cw.aluop   = 1'b0;
      end
      MEMRD: begin
        cw.adrsrc    = 1'b1;
        cw.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        cw.resultsrc = RES_RDATA;
        cw.regw      = 1'b1;
      end
      MEMWR: begin
        cw.adrsrc    = 1'b1;
        cw.resultsrc = RES_ALUOUT;
        cw.memw      = 1'b1;
      end
      EXECR: begin
        cw.alusrca = 1'b0;
        cw.alusrcb = SRCB_REG;
        cw.aluop   = 1'b1;
      end
      EXECI: begin
        cw.alusrca = 1'b0;
        cw.alusrcb = SRCB_EXTIMM;
        cw.aluop   = 1'b1;
      end
      ALUWB: begin
        cw.resultsrc = RES_ALUOUT;
        cw.regw      = 1'b1;
      end
      BRANCH: begin
        cw.alusrca   = 1'b0;
        cw.alusrcb   = SRCB_EXTIMM;
        cw.aluop     = 1'b0;
        cw.resultsrc = RES_ALURESULT;
        cw.branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_fsm.sv
// Multi-cycle processor controller: state register and next-state logic;
// the output table lives in mc_outdec.
module mc_fsm
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  mc_fsm_if.master  bus
);

  state_e state_q, state_d;
  logic   mem_ready_eff;
  ctrl_t  cw;

  assign mem_ready_eff = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready_eff) state_d = DECODE;
      DECODE: begin
        case (op_e'(bus.Op))
          OP_MEM:    state_d = MEMADR;
          OP_DATA:   state_d = bus.Funct[FUNCT_I] ? EXECI : EXECR;
          OP_BRANCH: state_d = BRANCH;
          default:   state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.Funct[FUNCT_L] ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready_eff) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready_eff) state_d = FETCH;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready_eff),
    .hold      (reset),
    .cw        (cw)
  );

  assign bus.IRWrite   = cw.irwrite;
  assign bus.NextPC    = cw.nextpc;
  assign bus.AdrSrc    = cw.adrsrc;
  assign bus.ALUSrcA   = cw.alusrca;
  assign bus.ALUSrcB   = cw.alusrcb;
  assign bus.ResultSrc = cw.resultsrc;
  assign bus.ALUOp     = cw.aluop;
  assign bus.RegW      = cw.regw;
  assign bus.MemW      = cw.memw;
  assign bus.Branch    = cw.branch;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_mc_fsm.sv
// Bench for mc_fsm: directed cycle table, reset-abort sequence, and random
// instruction streams checked against an instruction-level path model.
module tb_mc_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mc_fsm_if bus ();
  mc_fsm_if bus_nh ();

  mc_fsm #(.MEM_HANDSHAKE(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  mc_fsm #(.MEM_HANDSHAKE(1'b0)) dut_nh (.clk(clk), .reset(reset), .bus(bus_nh.master));

  assign bus_nh.Op       = bus.Op;
  assign bus_nh.Funct    = bus.Funct;
  assign bus_nh.MemReady = bus.MemReady;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic       mr;
    state_e     st;
    logic [4:0] strb;  // {IRWrite, NextPC, RegW, MemW, Branch}
  } vec_t;

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], ALUOp, RegW, MemW, Branch}
  function automatic logic [11:0] act_ctrl();
    return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW, bus.Branch};
  endfunction

  // Expected control word per state; the mask covers only the fields the
  // state defines (strobes are always defined: absent means 0).
  task automatic exp_ctrl(input state_e s, input logic mr,
                          output logic [11:0] e, output logic [11:0] m);
    case (s)
      FETCH:  begin e = {mr, mr, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 3'b000}; m = '1; end
      DECODE: begin e = {2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 3'b000};
                    m = {2'b11, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 3'b111}; end
      MEMADR: begin e = {2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b000};
                    m = {2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 3'b111}; end
      MEMRD:  begin e = {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000};
                    m = {2'b11, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 3'b111}; end
      MEMWB:  begin e = {2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'b100};
                    m = {2'b11, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 3'b111}; end
      MEMWR:  begin e = {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010};
                    m = {2'b11, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 3'b111}; end
      EXECR:  begin e = {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'b000};
                    m = {2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 3'b111}; end
      EXECI:  begin e = {2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 3'b000};
                    m = {2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 3'b111}; end
      ALUWB:  begin e = {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b100};
                    m = {2'b11, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 3'b111}; end
      default: begin e = {2'b00, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 3'b001};
                    m = {2'b11, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 3'b111}; end // BRANCH
    endcase
  endtask

  // Called just after a rising edge: drive inputs, check on the falling edge.
  task automatic step(input logic [1:0] op, input logic [5:0] f, input logic mr,
                      input state_e es, input string tag);
    logic [11:0] e, m;
    bus.Op = op; bus.Funct = f; bus.MemReady = mr;
    @(negedge clk);
    chk({tag, "_state"}, 12'(bus.State), 12'(es));
    exp_ctrl(es, mr, e, m);
    chk({tag, "_ctrl"}, act_ctrl() & m, e & m);
    @(posedge clk); #1;
  endtask

  // Drive one instruction through the model path, with random wait states.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f);
    state_e path[$];
    logic   mr;
    int     w;
    logic   samp;
    path.push_back(FETCH);
    path.push_back(DECODE);
    case (op)
      2'b00: begin path.push_back(f[5] ? EXECI : EXECR); path.push_back(ALUWB); end
      2'b01: begin
        path.push_back(MEMADR);
        if (f[0]) begin path.push_back(MEMRD); path.push_back(MEMWB); end
        else       path.push_back(MEMWR);
      end
      2'b10: path.push_back(BRANCH);
      default: ;
    endcase
    foreach (path[i]) begin
      samp = (path[i] == DECODE) || (path[i] == MEMADR);
      if (path[i] == FETCH || path[i] == MEMRD || path[i] == MEMWR) begin
        w = 0;
        do begin
          mr = ($urandom_range(3) != 0) || (w >= 4);
          step(2'($urandom), 6'($urandom), mr, path[i], {"r_", path[i].name()});
          w++;
        end while (!mr);
      end else begin
        step(samp ? op : 2'($urandom), samp ? f : 6'($urandom), 1'($urandom),
             path[i], {"r_", path[i].name()});
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] e, m;
    // ADD reg
    tbl.push_back('{2'b00, 6'b001000, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b00, 6'b001000, 1'b1, DECODE, 5'b00000});
    tbl.push_back('{2'b11, 6'b111111, 1'b0, EXECR,  5'b00000});
    tbl.push_back('{2'b10, 6'b000000, 1'b1, ALUWB,  5'b00100});
    // data-proc immediate
    tbl.push_back('{2'b00, 6'b101000, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b00, 6'b101000, 1'b0, DECODE, 5'b00000});
    tbl.push_back('{2'b01, 6'b000001, 1'b1, EXECI,  5'b00000});
    tbl.push_back('{2'b00, 6'b001000, 1'b0, ALUWB,  5'b00100});
    // LDR with two wait cycles in MEMRD
    tbl.push_back('{2'b01, 6'b011001, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b01, 6'b011001, 1'b1, DECODE, 5'b00000});
    tbl.push_back('{2'b01, 6'b011001, 1'b0, MEMADR, 5'b00000});
    tbl.push_back('{2'b11, 6'b000000, 1'b0, MEMRD,  5'b00000});
    tbl.push_back('{2'b11, 6'b000000, 1'b0, MEMRD,  5'b00000});
    tbl.push_back('{2'b00, 6'b000000, 1'b1, MEMRD,  5'b00000});
    tbl.push_back('{2'b10, 6'b000000, 1'b0, MEMWB,  5'b00100});
    // STR with one wait cycle in MEMWR
    tbl.push_back('{2'b01, 6'b011000, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b01, 6'b011000, 1'b1, DECODE, 5'b00000});
    tbl.push_back('{2'b01, 6'b011000, 1'b1, MEMADR, 5'b00000});
    tbl.push_back('{2'b00, 6'b111111, 1'b0, MEMWR,  5'b00010});
    tbl.push_back('{2'b00, 6'b111111, 1'b1, MEMWR,  5'b00010});
    // B
    tbl.push_back('{2'b10, 6'b000000, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b10, 6'b000000, 1'b1, DECODE, 5'b00000});
    tbl.push_back('{2'b01, 6'b000001, 1'b0, BRANCH, 5'b00001});
    // fetch wait, then illegal
    tbl.push_back('{2'b11, 6'b000000, 1'b0, FETCH,  5'b00000});
    tbl.push_back('{2'b11, 6'b000000, 1'b1, FETCH,  5'b11000});
    tbl.push_back('{2'b11, 6'b000000, 1'b1, DECODE, 5'b00000});

    reset = 1'b1; bus.Op = 2'b00; bus.Funct = '0; bus.MemReady = 1'b1;
    #2;
    exp_ctrl(FETCH, 1'b0, e, m);
    chk("reset_state", 12'(bus.State), 12'(FETCH));
    chk("reset_ctrl", act_ctrl(), e);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold_ctrl", act_ctrl(), e);
    reset = 1'b0;

    // MemReady=0 in FETCH: handshake instance waits, no-handshake one advances
    bus.MemReady = 1'b0;
    @(negedge clk);
    chk("nh_irwrite", 12'(bus_nh.IRWrite), 12'd1);
    chk("hs_irwrite", 12'(bus.IRWrite), 12'd0);
    @(posedge clk); #1;
    chk("nh_state", 12'(bus_nh.State), 12'(DECODE));
    chk("hs_state", 12'(bus.State), 12'(FETCH));

    foreach (tbl[i]) begin
      bus.Op = tbl[i].op; bus.Funct = tbl[i].funct; bus.MemReady = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_strb", i),
          12'({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch}), 12'(tbl[i].strb));
      @(posedge clk); #1;
      // re-check after the edge would miss the row; step() covers state/selects
    end

    // reset in MEMWR with MemReady=0 aborts the store immediately
    step(2'b01, 6'b011000, 1'b1, FETCH,  "abort_f");
    step(2'b01, 6'b011000, 1'b1, DECODE, "abort_d");
    step(2'b01, 6'b011000, 1'b1, MEMADR, "abort_a");
    step(2'b01, 6'b011000, 1'b0, MEMWR,  "abort_w");
    bus.MemReady = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_state", 12'(bus.State), 12'(FETCH));
    chk("abort_memw", 12'(bus.MemW), 12'd0);
    chk("abort_irwrite", 12'(bus.IRWrite), 12'd0);
    bus.MemReady = 1'b1;
    #1;
    chk("abort_strobes_mr1", 12'({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch}), 12'd0);
    @(posedge clk); #1;
    chk("abort_hold_state", 12'(bus.State), 12'(FETCH));
    chk("abort_hold_irwrite", 12'(bus.IRWrite), 12'd0);
    reset = 1'b0;
    step(2'b10, 6'b000000, 1'b1, FETCH,  "post_f");
    step(2'b10, 6'b000000, 1'b1, DECODE, "post_d");
    step(2'b00, 6'b000000, 1'b1, BRANCH, "post_b");

    for (int k = 0; k < 150; k++) begin
      run_instr(2'($urandom), 6'($urandom));
    end
    step(2'b00, 6'b000000, 1'b0, FETCH, "final_f");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Cycle-level state/select check of the directed table, in parallel with the strobe column.
  initial begin
    logic [11:0] e, m;
    int idx;
    wait (reset === 1'b1);
    wait (reset === 1'b0);
    @(posedge clk); #1;
    idx = 0;
    while (idx < tbl.size()) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_state", idx), 12'(bus.State), 12'(tbl[idx].st));
      exp_ctrl(tbl[idx].st, tbl[idx].mr, e, m);
      chk($sformatf("tbl%0d_ctrl", idx), act_ctrl() & m, e & m);
      idx++;
    end
  end

endmodule
